mill_modif_frame_dec: RTL and testbench

Parametrised ISO 14443-A PCD->PICC Modified Miller frame decoder. It takes the single-cycle `pause` strobe from the pause detector and measures each pause's phase within the ETU with a resynchronising counter. It classifies every ETU as sequence X, Y or Z, detects SOF and EOF, and assembles LSB-first data bits into bytes with odd-parity checking. It sits between the pause detector and the frame/command layer, and adds framing, byte output, error flags and phase tolerance on top of bit-level demodulation.

---
 rtl/mill_modif_frame_dec.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mill_modif_frame_dec.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mill_modif_frame_dec.sv
`default_nettype none
// ============================================================================
//  Module   : mill_modif_frame_dec
//  Purpose  : ISO 14443-A PCD->PICC Modified Miller frame decoder. Measures
//             the phase of each pause strobe within the ETU using a counter
//             that resynchronises on every pause. Classifies each ETU as X,
//             Y or Z, detects SOF/EOF, and assembles LSB-first bytes with
//             odd-parity checking.
//  Ports    : clk, rst (async, active high), in_enable, pause
//             -> out_bit/out_bit_valid, sof, eof, byte_data/byte_valid,
//                parity_err, last_bits, code_err, busy
//  Revision : 1.0  initial release
// ============================================================================
module mill_modif_frame_dec #(
  parameter int ETU_CLKS = 16,
  parameter int TOL      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_enable,
  input  logic       pause,
  output logic       out_bit,
  output logic       out_bit_valid,
  output logic       sof,
  output logic       eof,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       parity_err,
  output logic [3:0] last_bits,
  output logic       code_err,
  output logic       busy
);

  localparam int HALF = ETU_CLKS / 2;
  localparam int CW   = $clog2(ETU_CLKS) + 1;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t C_LAST  = cnt_t'(ETU_CLKS - 1);
  localparam cnt_t C_TOL   = cnt_t'(TOL);
  localparam cnt_t C_EARLY = cnt_t'(ETU_CLKS - TOL);
  localparam cnt_t C_HLO   = cnt_t'(HALF - TOL);
  localparam cnt_t C_HHI   = cnt_t'(HALF + TOL);
  localparam cnt_t C_HALF1 = cnt_t'(HALF + 1);

  typedef enum logic {IDLE = 1'b0, RX = 1'b1} state_t;

  state_t     state, state_n;
  cnt_t       count, count_n;
  logic       seen, seen_n;          // a pause already landed in this ETU
  logic       seen_z, seen_z_n;      // that pause was a Z (start) pause
  logic       first, first_n;        // current ETU carries the SOF pause
  logic       prev_bit, prev_n;
  logic       pend_valid, pend_valid_n;
  logic       pend_bit, pend_bit_n;
  logic [7:0] shreg, shreg_n;
  logic [3:0] nbits, nbits_n;        // 0..8; 8 means next bit is parity

  logic       bit_n, bitv_n, sof_n, eof_n, bytev_n, perr_n, cerr_n;
  logic [7:0] byte_n;
  logic [3:0] last_n;

  logic       close_req, early, err, sym_ok, eof_sym, dec;

  assign busy = (state == RX);

  always_comb begin
    state_n      = state;
    count_n      = count;
    seen_n       = seen;
    seen_z_n     = seen_z;
    first_n      = first;
    prev_n       = prev_bit;
    pend_valid_n = pend_valid;
    pend_bit_n   = pend_bit;
    shreg_n      = shreg;
    nbits_n      = nbits;
    bit_n        = 1'b0;
    bitv_n       = 1'b0;
    sof_n        = 1'b0;
    eof_n        = 1'b0;
    bytev_n      = 1'b0;
    perr_n       = 1'b0;
    cerr_n       = 1'b0;
    byte_n       = byte_data;
    last_n       = last_bits;
    close_req    = 1'b0;
    early        = 1'b0;
    err          = 1'b0;
    sym_ok       = 1'b0;
    eof_sym      = 1'b0;
    dec          = 1'b0;

    if (!in_enable) begin
      state_n      = IDLE;
      count_n      = '0;
      seen_n       = 1'b0;
      seen_z_n     = 1'b0;
      first_n      = 1'b0;
      prev_n       = 1'b0;
      pend_valid_n = 1'b0;
      pend_bit_n   = 1'b0;
      shreg_n      = '0;
      nbits_n      = '0;
      byte_n       = '0;
      last_n       = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pause) begin
            // The SOF pause is count 0 of the SOF ETU.
            state_n      = RX;
            sof_n        = 1'b1;
            count_n      = cnt_t'(1);
            seen_n       = 1'b1;
            seen_z_n     = 1'b1;
            first_n      = 1'b1;
            prev_n       = 1'b0;
            pend_valid_n = 1'b0;
            pend_bit_n   = 1'b0;
            shreg_n      = '0;
            nbits_n      = '0;
          end
        end
        default: begin
          count_n = count + cnt_t'(1);
          if (pause) begin
            if (count >= C_EARLY) begin
              // Early Z pause: belongs to the next ETU.
              close_req = 1'b1;
              early     = 1'b1;
            end else if (count <= C_TOL) begin
              if (seen) err = 1'b1;
              else begin
                seen_n   = 1'b1;
                seen_z_n = 1'b1;
                count_n  = cnt_t'(1);
              end
            end else if (count >= C_HLO && count <= C_HHI) begin
              if (seen) err = 1'b1;
              else begin
                seen_n   = 1'b1;
                seen_z_n = 1'b0;
                count_n  = C_HALF1;
              end
            end else begin
              err = 1'b1;
            end
          end else if (count == C_LAST) begin
            close_req = 1'b1;
          end

          if (close_req) begin
            if (first) begin
              first_n = 1'b0;
            end else if (!seen) begin
              if (prev_bit) sym_ok  = 1'b1;   // Y after 1 -> 0
              else          eof_sym = 1'b1;   // Y after 0 -> EOF
            end else if (seen_z) begin
              if (prev_bit) err    = 1'b1;
              else          sym_ok = 1'b1;
            end else begin
              sym_ok = 1'b1;
              dec    = 1'b1;
            end

            if (early) begin
              seen_n   = 1'b1;
              seen_z_n = 1'b1;
              count_n  = cnt_t'(1);
            end else begin
              seen_n   = 1'b0;
              seen_z_n = 1'b0;
              count_n  = '0;
            end
            first_n = 1'b0;
          end

          // One-bit delay: the previous symbol's bit is released now.
          if (sym_ok) begin
            if (pend_valid) begin
              bit_n  = pend_bit;
              bitv_n = 1'b1;
              if (nbits == 4'd8) begin
                bytev_n = 1'b1;
                byte_n  = shreg;
                perr_n  = ~(^{shreg, pend_bit});
                shreg_n = '0;
                nbits_n = '0;
              end else begin
                shreg_n[nbits[2:0]] = pend_bit;
                nbits_n             = nbits + 4'd1;
              end
            end
            pend_valid_n = 1'b1;
            pend_bit_n   = dec;
            prev_n       = dec;
          end

          if (eof_sym) begin
            eof_n  = 1'b1;
            last_n = nbits;
            if (nbits != 4'd0) begin
              bytev_n = 1'b1;
              byte_n  = shreg;
            end
          end else if (err) begin
            cerr_n = 1'b1;
          end

          if (eof_sym || err) begin
            state_n      = IDLE;
            count_n      = '0;
            seen_n       = 1'b0;
            seen_z_n     = 1'b0;
            first_n      = 1'b0;
            prev_n       = 1'b0;
            pend_valid_n = 1'b0;
            pend_bit_n   = 1'b0;
            shreg_n      = '0;
            nbits_n      = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      seen          <= 1'b0;
      seen_z        <= 1'b0;
      first         <= 1'b0;
      prev_bit      <= 1'b0;
      pend_valid    <= 1'b0;
      pend_bit      <= 1'b0;
      shreg         <= '0;
      nbits         <= '0;
      out_bit       <= 1'b0;
      out_bit_valid <= 1'b0;
      sof           <= 1'b0;
      eof           <= 1'b0;
      byte_data     <= '0;
      byte_valid    <= 1'b0;
      parity_err    <= 1'b0;
      last_bits     <= '0;
      code_err      <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      seen          <= seen_n;
      seen_z        <= seen_z_n;
      first         <= first_n;
      prev_bit      <= prev_n;
      pend_valid    <= pend_valid_n;
      pend_bit      <= pend_bit_n;
      shreg         <= shreg_n;
      nbits         <= nbits_n;
      out_bit       <= bit_n;
      out_bit_valid <= bitv_n;
      sof           <= sof_n;
      eof           <= eof_n;
      byte_data     <= byte_n;
      byte_valid    <= bytev_n;
      parity_err    <= perr_n;
      last_bits     <= last_n;
      code_err      <= cerr_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mill_modif_frame_dec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mill_modif_frame_dec
//  Purpose  : Scoreboard bench for mill_modif_frame_dec. Frames are built as
//             bit lists, encoded to Miller symbols with phase jitter, and
//             played as pause strobes on a cycle timeline; the expected event
//             stream is derived from the bit list alone.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mill_modif_frame_dec;

  localparam int ETU_CLKS = 16;
  localparam int TOL      = 2;
  localparam int HALF     = ETU_CLKS / 2;

  localparam int S_X = 0, S_Y = 1, S_Z = 2, S_D = 3;   // D = two pauses in one ETU
  localparam int K_SOF = 0, K_BIT = 1, K_BYTE = 2, K_EOF = 3, K_ERR = 4;
  localparam int T_EOF = 0, T_ERR = 1, T_NONE = 2;

  logic       clk = 1'b0;
  logic       rst, in_enable, pause;
  logic       out_bit, out_bit_valid, sof, eof, byte_valid, parity_err, code_err, busy;
  logic [7:0] byte_data;
  logic [3:0] last_bits;

  always #5 clk = ~clk;

  mill_modif_frame_dec #(.ETU_CLKS(ETU_CLKS), .TOL(TOL)) dut (
    .clk(clk), .rst(rst), .in_enable(in_enable), .pause(pause),
    .out_bit(out_bit), .out_bit_valid(out_bit_valid), .sof(sof), .eof(eof),
    .byte_data(byte_data), .byte_valid(byte_valid), .parity_err(parity_err),
    .last_bits(last_bits), .code_err(code_err), .busy(busy)
  );

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic [3:0] aux;
  } ev_t;

  ev_t  exp_q[$];
  logic bit_q[$];
  int   sym_q[$];
  int   off_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push_ev(input int k, input logic [7:0] d, input logic [3:0] a);
    ev_t e;
    e.kind = k; e.data = d; e.aux = a;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [7:0] d, input logic [3:0] a, input string nm);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event kind=%0d data=%h aux=%0d, required no event", nm, k, d, a);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d || e.aux !== a)
        begin
          n_bad++;
          $display("FAIL %s: got kind=%0d data=%h aux=%0d, required kind=%0d data=%h aux=%0d",
                   nm, k, d, a, e.kind, e.data, e.aux);
        end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      if (sof)           check_ev(K_SOF, 8'h00, 4'd0, "sof");
      if (out_bit_valid) check_ev(K_BIT, {7'b0, out_bit}, 4'd0, "bit");
      if (byte_valid)    check_ev(K_BYTE, byte_data, {3'b0, parity_err}, "byte");
      if (eof)           check_ev(K_EOF, 8'h00, last_bits, "eof");
      if (code_err) begin
        check_ev(K_ERR, 8'h00, 4'd0, "code_err");
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL busy_at_code_err: got %b, required 0", busy);
        end
      end
    end
  end

  // Reference: expected events from the bit list. n_emit bits reach out_bit.
  task automatic expect_frame(input int n_emit, input int term);
    int         ones, r;
    logic [7:0] v;
    push_ev(K_SOF, 8'h00, 4'd0);
    for (int i = 0; i < n_emit; i++) begin
      push_ev(K_BIT, {7'b0, bit_q[i]}, 4'd0);
      if (i % 9 == 8) begin
        v = 8'h00; ones = 0;
        for (int k = 0; k < 9; k++) ones += int'(bit_q[i-8+k]);
        for (int k = 0; k < 8; k++) v[k] = bit_q[i-8+k];
        push_ev(K_BYTE, v, (ones % 2 == 0) ? 4'd1 : 4'd0);
      end
    end
    if (term == T_EOF) begin
      r = n_emit % 9;
      if (r > 0) begin
        v = 8'h00;
        for (int k = 0; k < r; k++) v[k] = bit_q[n_emit-r+k];
        push_ev(K_BYTE, v, 4'd0);
      end
      push_ev(K_EOF, 8'h00, 4'(r));
    end else if (term == T_ERR) begin
      push_ev(K_ERR, 8'h00, 4'd0);
    end
  endtask

  function automatic int offv(input int mode);
    case (mode)
      0:       return 0;
      1:       return int'($urandom_range(0, 2*TOL)) - TOL;
      2:       return TOL;
      default: return -TOL;
    endcase
  endfunction

  task automatic add_sym(input int s, input int d);
    sym_q.push_back(s);
    off_q.push_back(d);
  endtask

  // Miller encoding: 1 -> X, 0 after 1 -> Y, 0 after 0 -> Z; EOF = 0 then Y.
  task automatic build(input int mode, input bit with_eof);
    logic prev;
    sym_q.delete(); off_q.delete();
    prev = 1'b0;
    foreach (bit_q[i]) begin
      if (bit_q[i])  add_sym(S_X, offv(mode));
      else if (prev) add_sym(S_Y, 0);
      else           add_sym(S_Z, offv(mode));
      prev = bit_q[i];
    end
    if (with_eof) begin
      if (prev) add_sym(S_Y, 0); else add_sym(S_Z, offv(mode));
      add_sym(S_Y, 0);
    end
  endtask

  // Plays SOF plus sym_q; ends a few cycles into the ETU after the last one.
  task automatic play();
    int pt[$];
    int t, p, end_t;
    pt.push_back(0);
    t = ETU_CLKS;
    foreach (sym_q[i]) begin
      case (sym_q[i])
        S_X: begin p = t + HALF + off_q[i]; pt.push_back(p); t = p + HALF; end
        S_Z: begin p = t + off_q[i]; pt.push_back(p); t = p + ETU_CLKS; end
        S_Y: t = t + ETU_CLKS;
        default: begin pt.push_back(t); pt.push_back(t + HALF); t = t + ETU_CLKS; end
      endcase
    end
    end_t = t + 3;
    for (int c = 0; c <= end_t; c++) begin
      @(negedge clk);
      if (pt.size() > 0 && pt[0] == c) begin
        pause = 1'b1;
        void'(pt.pop_front());
      end else begin
        pause = 1'b0;
      end
    end
    @(negedge clk);
    pause = 1'b0;
  endtask

  task automatic check_empty(input string nm);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected events never appeared, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string nm);
    logic [22:0] v;
    v = {sof, eof, out_bit, out_bit_valid, byte_data, byte_valid, parity_err,
         last_bits, code_err, busy};
    n_cmp++;
    if (v !== 23'd0) begin
      n_bad++;
      $display("FAIL %s: outputs=%h, required all 0", nm, v);
    end
  endtask

  task automatic set_bits(input logic [31:0] v, input int n);
    bit_q.delete();
    for (int i = 0; i < n; i++) bit_q.push_back(v[i]);
  endtask

  task automatic run_frame(input int mode, input string nm);
    build(mode, 1'b1);
    expect_frame(bit_q.size(), T_EOF);
    play();
    repeat (4) @(negedge clk);
    check_empty(nm);
  endtask

  initial begin
    rst = 1'b1; in_enable = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0; in_enable = 1'b1;
    repeat (2) @(negedge clk);

    // REQA 0x26, 7 bits
    set_bits(32'h26, 7);
    run_frame(0, "reqa");

    // SEL 0x93 with good then bad parity
    set_bits({23'd0, 1'b1, 8'h93}, 9);
    run_frame(0, "sel_par_ok");
    set_bits({23'd0, 1'b0, 8'h93}, 9);
    run_frame(0, "sel_par_bad");

    // Phase tolerance at both edges of the window
    set_bits(32'h0000_2D5, 11);
    run_frame(2, "tol_plus");
    run_frame(3, "tol_minus");

    // Y right after SOF
    sym_q.delete(); off_q.delete(); bit_q.delete();
    add_sym(S_Y, 0);
    expect_frame(0, T_EOF);
    play(); repeat (4) @(negedge clk);
    check_empty("eof_after_sof");

    // X outside tolerance
    set_bits(32'h3, 2);
    build(0, 1'b0);
    add_sym(S_X, TOL + 1);
    expect_frame(1, T_ERR);
    play(); repeat (4) @(negedge clk);
    check_empty("tol_reject");

    // Z after X
    set_bits(32'h1, 1);
    build(0, 1'b0);
    add_sym(S_Z, 0);
    expect_frame(0, T_ERR);
    play(); repeat (4) @(negedge clk);
    check_empty("z_after_x");

    // Two pauses in one ETU
    set_bits(32'h0, 1);
    build(0, 1'b0);
    add_sym(S_D, 0);
    expect_frame(0, T_ERR);
    play(); repeat (4) @(negedge clk);
    check_empty("double_pause");

    // Reset mid-byte
    set_bits(32'h15, 5);
    build(1, 1'b0);
    expect_frame(4, T_NONE);
    play();
    rst = 1'b1;
    #1 check_idle("rst_mid_frame");
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    check_empty("rst_mid_frame_events");

    // Enable dropped mid-frame, with a simultaneous pause that must be ignored
    set_bits(32'h0B, 6);
    build(1, 1'b0);
    expect_frame(5, T_NONE);
    play();
    in_enable = 1'b0; pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    check_idle("enable_drop");
    @(negedge clk); in_enable = 1'b1;
    repeat (3) @(negedge clk);
    check_empty("enable_drop_events");

    // Fresh frame after the aborts
    set_bits(32'h26, 7);
    run_frame(1, "reqa_after_abort");

    // Randomised good frames
    for (int f = 0; f < 30; f++) begin
      bit_q.delete();
      for (int i = 0; i < int'($urandom_range(0, 27)); i++)
        bit_q.push_back(1'($urandom_range(0, 1)));
      run_frame(1, "rand_frame");
    end

    // Randomised error frames
    for (int f = 0; f < 12; f++) begin
      int n, kind;
      bit_q.delete();
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) bit_q.push_back(1'($urandom_range(0, 1)));
      build(1, 1'b0);
      kind = int'($urandom_range(0, 2));
      if (kind == 0)      add_sym(bit_q[n-1] ? S_Z : S_D, 0);
      else if (kind == 1) add_sym(S_X, TOL + 1);
      else                add_sym(S_X, -(TOL + 1));
      expect_frame(n - 1, T_ERR);
      play(); repeat (4) @(negedge clk);
      check_empty("rand_err_frame");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
